// File: rtl/ms_slave_feeder.sv
// Paced feeder: buffers producer words in a small FIFO and replays them as a
// held value plus a one-cycle sync pulse, with at least PERIOD cycles between pulses.
//
// section  | meaning
// SEC_IDLE | ready to pop the head word as soon as the FIFO is non-empty
// SEC_WAIT | pulse issued, timer counting down the remaining spacing
module ms_slave_feeder #(
    parameter int DEPTH     = 4,
    parameter int PERIOD    = 3,
    parameter int RESET_VAL = 1337
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                m_in,
    input  logic                       m_in_sync,
    output logic                       m_in_notify,
    output logic [31:0]                s_out,
    output logic                       s_out_sync,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(PERIOD + 1);

    typedef enum logic {SEC_IDLE, SEC_WAIT} sec_t;

    sec_t          section;
    logic [TW-1:0] timer;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem [DEPTH];
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Both decisions use the pre-edge level, so a word pushed into an empty
    // FIFO is only seen by IDLE one edge later, and a full FIFO rejects a push
    // even when a pop happens on the same edge.
    assign m_in_notify = (level != LW'(DEPTH));
    assign push        = m_in_sync && m_in_notify;
    assign pop         = (section == SEC_IDLE) && (level != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= m_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            section    <= SEC_IDLE;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            s_out      <= 32'(RESET_VAL);
            s_out_sync <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            case (section)
                SEC_IDLE: begin
                    if (pop) begin
                        s_out      <= mem[rd_ptr];
                        s_out_sync <= 1'b1;
                        timer      <= TW'(PERIOD - 1);
                        section    <= SEC_WAIT;
                    end else begin
                        s_out_sync <= 1'b0;
                    end
                end
                SEC_WAIT: begin
                    s_out_sync <= 1'b0;
                    if (timer == TW'(1)) section <= SEC_IDLE;
                    else                 timer   <= timer - 1'b1;
                end
                default: begin
                    s_out_sync <= 1'b0;
                    section    <= SEC_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ms_slave_feeder.sv
// Self-checking bench for ms_slave_feeder: a queue-based reference model with
// pulse spacing tracked as "cycles since the last pulse".
module tb_ms_slave_feeder;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 3;
    localparam int LW     = $clog2(DEPTH + 1);

    logic          clk = 0;
    logic          rst = 1;
    logic [31:0]   m_in = '0;
    logic          m_in_sync = 0;
    logic          m_in_notify;
    logic [31:0]   s_out;
    logic          s_out_sync;
    logic [LW-1:0] level;

    ms_slave_feeder #(.DEPTH(DEPTH), .PERIOD(PERIOD), .RESET_VAL(1337)) dut (
        .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync),
        .m_in_notify(m_in_notify), .s_out(s_out), .s_out_sync(s_out_sync), .level(level)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] q[$];
    logic [31:0] m_sout = 32'd1337;
    bit          m_sync = 0;
    int          since  = PERIOD;
    bit          acc    = 0;
    int          cyc    = 0;
    int          total  = 0;
    int          bad    = 0;

    // Drive one cycle of stimulus and advance the model across the same edge.
    task automatic tick(input bit r, input bit s, input logic [31:0] d);
        int pre;
        @(negedge clk);
        rst = r; m_in_sync = s; m_in = d;
        if (r) begin
            q.delete();
            m_sout = 32'd1337; m_sync = 0; since = PERIOD; acc = 0;
        end else begin
            pre = q.size();
            acc = s && (pre != DEPTH);
            if (pre > 0 && since >= PERIOD) begin
                m_sout = q.pop_front(); m_sync = 1; since = 1;
            end else begin
                m_sync = 0;
                if (since < PERIOD) since++;
            end
            if (acc) q.push_back(d);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        tick(1, 0, 0); tick(1, 0, 0);
        total++; if (s_out !== 32'd1337) begin bad++; $display("FAIL reset_out got=%0d want=1337", s_out); end
        total++; if (s_out_sync !== 1'b0) begin bad++; $display("FAIL reset_sync got=%0b want=0", s_out_sync); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (m_in_notify !== 1'b1) begin bad++; $display("FAIL reset_notify got=%0b want=1", m_in_notify); end
        tick(0, 0, 0);
        total++; if (s_out !== 32'd1337 || s_out_sync !== 1'b0 || m_in_notify !== 1'b1) begin
            bad++; $display("FAIL reset_idle out=%0d sync=%0b rdy=%0b want 1337/0/1", s_out, s_out_sync, m_in_notify);
        end
    endtask

    task automatic test_single();
        tick(0, 1, 32'd42);
        total++; if (s_out_sync !== 1'b0 || level !== LW'(1)) begin
            bad++; $display("FAIL single_e1 sync=%0b lvl=%0d want 0/1", s_out_sync, level);
        end
        tick(0, 0, 0);
        total++; if (s_out !== 32'd42 || s_out_sync !== 1'b1 || level !== '0) begin
            bad++; $display("FAIL single_e2 out=%0d sync=%0b lvl=%0d want 42/1/0", s_out, s_out_sync, level);
        end
        tick(0, 0, 0);
        total++; if (s_out !== 32'd42 || s_out_sync !== 1'b0) begin
            bad++; $display("FAIL single_e3 out=%0d sync=%0b want 42/0", s_out, s_out_sync);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
    endtask

    task automatic test_burst();
        logic [31:0] got[$];
        int          pc[$];
        int          v = 1;
        bit          saw_full = 0;
        for (int n = 0; n < 60 && got.size() < 6; n++) begin
            tick(0, v <= 6, 32'(v));
            if (acc) v++;
            total++;
            if (s_out !== m_sout || s_out_sync !== m_sync || level !== LW'(q.size()) || m_in_notify !== (q.size() != DEPTH)) begin
                bad++; $display("FAIL burst cyc=%0d got out=%0d sync=%0b lvl=%0d rdy=%0b want out=%0d sync=%0b lvl=%0d",
                                cyc, s_out, s_out_sync, level, m_in_notify, m_sout, m_sync, q.size());
            end
            if (m_in_notify === 1'b0) saw_full = 1;
            if (s_out_sync === 1'b1) begin got.push_back(s_out); pc.push_back(cyc); end
        end
        total++; if (got.size() != 6) begin bad++; $display("FAIL burst_count got=%0d want=6", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 32'(i + 1)) begin bad++; $display("FAIL burst_order idx=%0d got=%0d want=%0d", i, got[i], i + 1); end
            if (i > 0) begin
                total++; if (pc[i] - pc[i-1] != PERIOD) begin bad++; $display("FAIL burst_space idx=%0d got=%0d want=%0d", i, pc[i] - pc[i-1], PERIOD); end
            end
        end
        total++; if (!saw_full) begin bad++; $display("FAIL burst_notify_drop got=never want=seen"); end
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
    endtask

    task automatic test_full_pop();
        int  v = 100;
        bit  hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (q.size() == DEPTH && since >= PERIOD) hit = 1;
            else begin
                tick(0, 1, 32'(v));
                if (acc) v++;
                total++;
                if (s_out !== m_sout || s_out_sync !== m_sync || level !== LW'(q.size()) || m_in_notify !== (q.size() != DEPTH)) begin
                    bad++; $display("FAIL fill cyc=%0d got out=%0d sync=%0b lvl=%0d want out=%0d sync=%0b lvl=%0d",
                                    cyc, s_out, s_out_sync, level, m_sout, m_sync, q.size());
                end
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL full_pop_setup got=timeout want=full_idle"); end
        tick(0, 1, 32'd500);
        total++; if (level !== LW'(DEPTH - 1) || s_out_sync !== 1'b1 || m_in_notify !== 1'b1) begin
            bad++; $display("FAIL full_pop_reject lvl=%0d sync=%0b rdy=%0b want %0d/1/1", level, s_out_sync, m_in_notify, DEPTH - 1);
        end
        tick(0, 1, 32'd500);
        total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_pop_accept lvl=%0d want=%0d", level, DEPTH); end
        for (int n = 0; n < 40 && (q.size() != 0 || since < PERIOD); n++) begin
            tick(0, 0, 0);
            total++;
            if (s_out !== m_sout || s_out_sync !== m_sync || level !== LW'(q.size())) begin
                bad++; $display("FAIL full_drain cyc=%0d got out=%0d sync=%0b lvl=%0d want out=%0d sync=%0b lvl=%0d",
                                cyc, s_out, s_out_sync, level, m_sout, m_sync, q.size());
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int          v = 10;
        for (int n = 0; n < 150 && got.size() < 10; n++) begin
            tick(0, (v <= 19) && ($urandom_range(0, 3) != 0), 32'(v));
            if (acc) v++;
            total++;
            if (s_out !== m_sout || s_out_sync !== m_sync || level !== LW'(q.size()) || m_in_notify !== (q.size() != DEPTH)) begin
                bad++; $display("FAIL wrap cyc=%0d got out=%0d sync=%0b lvl=%0d want out=%0d sync=%0b lvl=%0d",
                                cyc, s_out, s_out_sync, level, m_sout, m_sync, q.size());
            end
            if (s_out_sync === 1'b1) got.push_back(s_out);
        end
        total++; if (got.size() != 10) begin bad++; $display("FAIL wrap_count got=%0d want=10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 32'(10 + i)) begin bad++; $display("FAIL wrap_order idx=%0d got=%0d want=%0d", i, got[i], 10 + i); end
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int v = 200;
        for (int n = 0; n < 40 && !hit; n++) begin
            tick(0, q.size() < 3, 32'(v));
            if (acc) v++;
            if (m_sync && q.size() == 2) hit = 1;
        end
        total++; if (!hit || level !== LW'(2) || s_out_sync !== 1'b1) begin
            bad++; $display("FAIL midrst_setup hit=%0b lvl=%0d sync=%0b want 1/2/1", hit, level, s_out_sync);
        end
        tick(1, 0, 0);
        total++; if (s_out !== 32'd1337 || level !== '0 || s_out_sync !== 1'b0) begin
            bad++; $display("FAIL midrst out=%0d lvl=%0d sync=%0b want 1337/0/0", s_out, level, s_out_sync);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            total++; if (s_out_sync !== 1'b0 || s_out !== 32'd1337 || level !== '0) begin
                bad++; $display("FAIL midrst_quiet cyc=%0d out=%0d sync=%0b lvl=%0d want 1337/0/0", cyc, s_out, s_out_sync, level);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1, $urandom);
            total++;
            if (s_out !== m_sout || s_out_sync !== m_sync || level !== LW'(q.size()) || m_in_notify !== (q.size() != DEPTH)) begin
                bad++; $display("FAIL random cyc=%0d got out=%0h sync=%0b lvl=%0d rdy=%0b want out=%0h sync=%0b lvl=%0d",
                                cyc, s_out, s_out_sync, level, m_in_notify, m_sout, m_sync, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
